// File: rtl/reciprocal_pkg.sv
// Shared types and constants for the iterative restoring-division reciprocal unit.
package reciprocal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    // Bit width of the quotient-bit counter for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(2 * width);
    endfunction

    // All-ones 2*width-bit pattern, right-aligned in 64 bits.
    function automatic logic [63:0] sat_ones(input int unsigned width);
        return (64'd1 << (2 * width)) - 64'd1;
    endfunction

    localparam int unsigned DEF_WIDTH    = 8;
    localparam logic [63:0] DEF_SAT_ONES = sat_ones(DEF_WIDTH);

endpackage

// File: rtl/recip_step.sv
// One combinational radix-2 restoring division step: shift partial remainder, trial-subtract divisor.
module recip_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH:0]   r_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] diff;

    // r_i < a_i always holds, so the borrow out of the wide subtract decides the quotient bit.
    always_comb begin
        diff   = {r_i, 1'b0} - {2'b00, a_i};
        qbit_o = ~diff[WIDTH+1];
        r_o    = qbit_o ? diff[WIDTH:0] : {r_i[WIDTH-1:0], 1'b0};
    end

endmodule

// File: rtl/reciprocal_rd.sv
// Reciprocal 2^(2*WIDTH)/A of an unsigned fraction, one quotient bit per clock, behind a four-phase req/ack handshake.
module reciprocal_rd
    import reciprocal_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req,
    input  logic [WIDTH-1:0]   A,
    input  logic               rnd,
    output logic [2*WIDTH-1:0] P,
    output logic               ack,
    output logic               busy,
    output logic               dz,
    output logic               sat
);

    localparam int unsigned  CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(2 * WIDTH - 1);
    localparam logic [63:0]  SAT_FULL = sat_ones(WIDTH);
    localparam logic [2*WIDTH-1:0] SAT_ONES = SAT_FULL[2*WIDTH-1:0];

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 rnd_q, rnd_d;
    logic [WIDTH:0]       r_q, r_d;
    logic [2*WIDTH-1:0]   q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 dz_q, dz_d;
    logic                 sat_q, sat_d;

    logic [WIDTH:0]       r_step;
    logic                 qbit;
    logic                 a_zero, a_one, round_up;

    recip_step #(.WIDTH(WIDTH)) u_step (
        .r_i    (r_q),
        .a_i    (a_q),
        .r_o    (r_step),
        .qbit_o (qbit)
    );

    assign a_zero   = (A == '0);
    assign a_one    = (A == WIDTH'(1));
    assign round_up = ({r_q, 1'b0} >= {2'b00, a_q});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            rnd_q   <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rnd_q   <= rnd_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = (a_zero || a_one) ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = FIN;
            FIN:     state_d = DONE;
            DONE:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        rnd_d  = rnd_q;
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        p_d    = p_q;
        ack_d  = ack_q;
        busy_d = busy_q;
        dz_d   = dz_q;
        sat_d  = sat_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d   = A;
                    rnd_d = rnd;
                    if (a_zero || a_one) begin
                        p_d   = SAT_ONES;
                        dz_d  = a_zero;
                        sat_d = a_one;
                        ack_d = 1'b1;
                    end else begin
                        r_d    = (WIDTH + 1)'(1);
                        q_d    = '0;
                        cnt_d  = CNT_INIT;
                        busy_d = 1'b1;
                    end
                end
            end
            CALC: begin
                r_d        = r_step;
                q_d[cnt_q] = qbit;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            FIN: begin
                p_d    = (rnd_q && round_up) ? q_q + 1'b1 : q_q;
                dz_d   = 1'b0;
                sat_d  = 1'b0;
                ack_d  = 1'b1;
                busy_d = 1'b0;
            end
            DONE: begin
                if (!req) ack_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign P    = p_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign dz   = dz_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_reciprocal_rd.sv
// Self-checking bench for reciprocal_rd (WIDTH=8): vector table plus handshake corner sequences, scoreboard-checked.
module tb_reciprocal_rd;

    typedef struct {
        logic [15:0] p;
        logic        dz;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic        rnd;
        logic [15:0] p;
        logic        dz;
        logic        sat;
        int unsigned lat;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  A;
    logic        rnd;
    logic [15:0] P;
    logic        ack, busy, dz, sat;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    vec_t        vecs[14];

    reciprocal_rd #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .A     (A),
        .rnd   (rnd),
        .P     (P),
        .ack   (ack),
        .busy  (busy),
        .dz    (dz),
        .sat   (sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pop_and_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({name, "_P"}, 32'(P), 32'(e.p));
        chk({name, "_dz"}, 32'(dz), 32'(e.dz));
        chk({name, "_sat"}, 32'(sat), 32'(e.sat));
    endtask

    // lat counts edges after the one that sampled req; busy is sampled 1 ns after every edge until ack.
    task automatic txn(input vec_t v, input string name);
        int unsigned lat, bcnt;
        logic [15:0] held;
        bit done;
        @(negedge clock);
        A = v.a; rnd = v.rnd; req = 1'b1;
        sb.push_back('{v.p, v.dz, v.sat});
        @(posedge clock);
        lat = 0; bcnt = 0; done = 0;
        while (!done) begin
            #1;
            if (busy) bcnt++;
            if (ack || lat >= 100) done = 1;
            else begin
                @(posedge clock);
                lat++;
            end
        end
        chk({name, "_ack_seen"}, 32'(ack), 32'd1);
        chk({name, "_latency"}, lat, v.lat);
        chk({name, "_busy_cycles"}, bcnt, (v.lat == 0) ? 32'd0 : v.lat);
        pop_and_check(name);
        held = P;
        @(negedge clock);
        req = 1'b0; A = 8'($urandom); rnd = 1'($urandom);
        @(posedge clock); #1;
        chk({name, "_ack_fall"}, 32'(ack), 32'd0);
        chk({name, "_P_hold"}, 32'(P), 32'(held));
    endtask

    initial begin
        int unsigned n, acnt, rises;
        bit stable, seen, prev;

        vecs[0]  = '{8'hE1, 1'b0, 16'h0123, 1'b0, 1'b0, 17};
        vecs[1]  = '{8'hF7, 1'b0, 16'h0109, 1'b0, 1'b0, 17};
        vecs[2]  = '{8'h94, 1'b0, 16'h01BA, 1'b0, 1'b0, 17};
        vecs[3]  = '{8'hA0, 1'b0, 16'h0199, 1'b0, 1'b0, 17};
        vecs[4]  = '{8'hC0, 1'b0, 16'h0155, 1'b0, 1'b0, 17};
        vecs[5]  = '{8'hE1, 1'b1, 16'h0123, 1'b0, 1'b0, 17};
        vecs[6]  = '{8'hF7, 1'b1, 16'h0109, 1'b0, 1'b0, 17};
        vecs[7]  = '{8'h94, 1'b1, 16'h01BB, 1'b0, 1'b0, 17};
        vecs[8]  = '{8'hA0, 1'b1, 16'h019A, 1'b0, 1'b0, 17};
        vecs[9]  = '{8'hC0, 1'b1, 16'h0155, 1'b0, 1'b0, 17};
        vecs[10] = '{8'h00, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0};
        vecs[11] = '{8'h01, 1'b0, 16'hFFFF, 1'b0, 1'b1, 0};
        vecs[12] = '{8'h03, 1'b1, 16'h5555, 1'b0, 1'b0, 17};
        vecs[13] = '{8'hFF, 1'b0, 16'h0101, 1'b0, 1'b0, 17};

        reset = 1'b1; req = 1'b0; A = '0; rnd = 1'b0;
        #12;
        chk("reset_P", 32'(P), 32'h0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);
        chk("reset_sat", 32'(sat), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) txn(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-CALC: everything clears before the next edge, pending result discarded.
        @(negedge clock);
        A = 8'h94; rnd = 1'b0; req = 1'b1;
        sb.push_back('{16'h01BA, 1'b0, 1'b0});
        repeat (5) @(posedge clock);
        #1;
        chk("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_ack", 32'(ack), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_P", 32'(P), 32'h0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0; req = 1'b0;
        txn('{8'hC0, 1'b0, 16'h0155, 1'b0, 1'b0, 17}, "after_reset");

        // req high for two edges only, dropped during CALC.
        @(negedge clock);
        A = 8'h80; rnd = 1'b0; req = 1'b1;
        sb.push_back('{16'h0200, 1'b0, 1'b0});
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        req = 1'b0; A = 8'h07;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!ack && n < 40);
        chk("short_req_ack_seen", 32'(ack), 32'd1);
        pop_and_check("short_req");
        acnt = 1;
        repeat (3) begin
            @(posedge clock); #1;
            if (ack) acnt++;
        end
        chk("short_req_ack_cycles", acnt, 32'd1);

        // req held for 40 cycles: one transaction, ack held, A change after sampling ignored.
        @(negedge clock);
        A = 8'h94; rnd = 1'b1; req = 1'b1;
        sb.push_back('{16'h01BB, 1'b0, 1'b0});
        rises = 0; stable = 1; seen = 0; prev = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (c == 2) begin A = 8'h11; rnd = 1'b0; end
            if (ack && !prev) begin
                rises++;
                if (!seen) pop_and_check("hold_req");
                seen = 1;
            end
            if (seen && P !== 16'h01BB) stable = 0;
            prev = ack;
        end
        chk("hold_req_one_txn", rises, 32'd1);
        chk("hold_req_ack_held", 32'(ack), 32'd1);
        chk("hold_req_P_stable", 32'(stable), 32'd1);
        chk("hold_req_busy_low", 32'(busy), 32'd0);
        @(negedge clock);
        req = 1'b0;
        @(posedge clock); #1;
        chk("hold_req_ack_fall", 32'(ack), 32'd0);
        chk("hold_req_P_after", 32'(P), 32'h01BB);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
